// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port RAM between instruction fetch (IF) and the MEM
//   stage. Each access is sequenced over a fixed RAM read latency. MEM has
//   priority over IF, and an access is never preempted once it has started.
//   A taken-branch flush squashes the pending IF response.
//
// Handshake: a requester raises req and holds it (with stable address/data)
//   until its done pulse (IF may also abandon the request with if_flush).
//   done is a one-cycle pulse; x_rdata is valid while done=1. In the cycle
//   after done the requester either drops req or presents a new request.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   if_req/if_addr/if_flush         IF read request, word address, squash
//   if_rdata/if_done                IF read data and completion pulse
//   mem_req/we/sel/addr/wdata       MEM load/store request
//   mem_rdata/mem_done              MEM load data and completion pulse
//   ram_ce/we/sel/addr/wdata        RAM command (ram_ce is a 1-cycle strobe)
//   ram_rdata                       RAM read data, MEM_LAT cycles after ram_ce
//   stallreq_if/stallreq_mem        combinational stall requests
//   state                           current FSM state (debug observation)
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int MEM_LAT = 2  // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [3:0]  ram_sel,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        stallreq_if,
  output logic        stallreq_mem,
  output logic [1:0]  state
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] BUSY_IF  = 2'd1;
  localparam logic [1:0] BUSY_MEM = 2'd2;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  logic [3:0] cnt;
  logic       squash;

  // A requester whose done pulse is high this cycle is not re-arbitrated:
  // its req may still be high only because it has not yet seen done.
  logic mem_elig;
  logic if_elig;
  logic if_kill;

  assign mem_elig = mem_req & ~mem_done;
  assign if_elig  = if_req & ~if_done & ~if_flush;
  // A flush arriving in the very cycle the data returns must still squash.
  assign if_kill  = squash | if_flush;

  assign stallreq_if  = if_req & ~if_done & ~if_flush;
  assign stallreq_mem = mem_req & ~mem_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      squash    <= 1'b0;
      ram_ce    <= 1'b0;
      ram_we    <= 1'b0;
      ram_sel   <= 4'd0;
      ram_addr  <= 32'd0;
      ram_wdata <= 32'd0;
      if_rdata  <= 32'd0;
      if_done   <= 1'b0;
      mem_rdata <= 32'd0;
      mem_done  <= 1'b0;
    end else begin
      // Strobes and done pulses default low; they are set for one cycle only.
      ram_ce   <= 1'b0;
      if_done  <= 1'b0;
      mem_done <= 1'b0;

      case (state)
        IDLE: begin
          squash <= 1'b0;
          cnt    <= 4'd0;
          if (mem_elig) begin
            state     <= BUSY_MEM;
            ram_ce    <= 1'b1;
            ram_we    <= mem_we;
            ram_sel   <= mem_sel;
            ram_addr  <= mem_addr;
            ram_wdata <= mem_wdata;
          end else if (if_elig) begin
            state     <= BUSY_IF;
            ram_ce    <= 1'b1;
            ram_we    <= 1'b0;
            ram_sel   <= 4'hF;
            ram_addr  <= if_addr;
            ram_wdata <= 32'd0;
          end
        end

        BUSY_IF: begin
          cnt <= cnt + 4'd1;
          if (if_flush) squash <= 1'b1;
          if (cnt == LAT) begin
            state  <= IDLE;
            squash <= 1'b0;
            if (!if_kill) begin
              if_rdata <= ram_rdata;
              if_done  <= 1'b1;
            end
          end
        end

        BUSY_MEM: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAT) begin
            state     <= IDLE;
            mem_rdata <= ram_rdata;
            mem_done  <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter with MEM_LAT=2. A small behavioural RAM
//   returns read data exactly MEM_LAT cycles after ram_ce and drives junk in
//   every other cycle, so a capture at the wrong cycle shows up as bad data.
//   Cycle numbering inside each test: cycle 0 is the cycle in which the
//   request is first presented; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int MEM_LAT = 2;
  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        ram_ce;
  logic        ram_we;
  logic [3:0]  ram_sel;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        stallreq_if;
  logic        stallreq_mem;
  logic [1:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_sel(ram_sel),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
    .state(state)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural RAM (latency MEM_LAT=2) ----------------
  logic [31:0] ram_mem [0:255];
  logic [31:0] pipe0;
  logic [31:0] pipe1;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= 32'd0;
      ram_mem[64]  <= 32'hDEAD_BEEF;  // 0x100
      ram_mem[128] <= 32'hCAFE_F00D;  // 0x200
      pipe0 <= JUNK;
      pipe1 <= JUNK;
    end else begin
      if (ram_ce && ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_sel[b]) ram_mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
      pipe0 <= (ram_ce && !ram_we) ? ram_mem[ram_addr[9:2]] : JUNK;
      pipe1 <= pipe0;
    end
  end
  assign ram_rdata = pipe1;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = 32'd0; if_flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_sel = 4'd0;
    mem_addr = 32'd0; mem_wdata = 32'd0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    n_checks += 12;
    if (ram_ce !== 1'b0) begin n_fail++; $display("FAIL reset_ram_ce: got %b expected 0", ram_ce); end
    if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we: got %b expected 0", ram_we); end
    if (ram_sel !== 4'd0) begin n_fail++; $display("FAIL reset_ram_sel: got %h expected 0", ram_sel); end
    if (ram_addr !== 32'd0) begin n_fail++; $display("FAIL reset_ram_addr: got %h expected 0", ram_addr); end
    if (ram_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_ram_wdata: got %h expected 0", ram_wdata); end
    if (if_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_if_rdata: got %h expected 0", if_rdata); end
    if (mem_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_mem_rdata: got %h expected 0", mem_rdata); end
    if (if_done !== 1'b0) begin n_fail++; $display("FAIL reset_if_done: got %b expected 0", if_done); end
    if (mem_done !== 1'b0) begin n_fail++; $display("FAIL reset_mem_done: got %b expected 0", mem_done); end
    if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    if (stallreq_if !== 1'b0) begin n_fail++; $display("FAIL reset_stallreq_if: got %b expected 0", stallreq_if); end
    if (stallreq_mem !== 1'b0) begin n_fail++; $display("FAIL reset_stallreq_mem: got %b expected 0", stallreq_mem); end
  endtask

  task automatic test_if_read();
    step();  // cycle 0
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    n_checks++;
    if (stallreq_if !== 1'b1) begin n_fail++; $display("FAIL ifrd_stall_c0: got %b expected 1", stallreq_if); end
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 5) if_req = 1'b0;
      @(negedge clk);
      n_checks += 2;
      if (ram_ce !== (c == 1)) begin n_fail++; $display("FAIL ifrd_ram_ce c%0d: got %b expected %b", c, ram_ce, c == 1); end
      if (if_done !== (c == 4)) begin n_fail++; $display("FAIL ifrd_if_done c%0d: got %b expected %b", c, if_done, c == 4); end
      if (c == 1) begin
        n_checks += 3;
        if (ram_addr !== 32'h100) begin n_fail++; $display("FAIL ifrd_ram_addr: got %h expected 100", ram_addr); end
        if (ram_sel !== 4'hF) begin n_fail++; $display("FAIL ifrd_ram_sel: got %h expected f", ram_sel); end
        if (ram_we !== 1'b0) begin n_fail++; $display("FAIL ifrd_ram_we: got %b expected 0", ram_we); end
      end
      if (c == 4) begin
        n_checks += 2;
        if (if_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ifrd_if_rdata: got %h expected deadbeef", if_rdata); end
        if (stallreq_if !== 1'b0) begin n_fail++; $display("FAIL ifrd_stall_done: got %b expected 0", stallreq_if); end
      end
    end
  endtask

  task automatic test_arbitration();
    step();  // cycle 0
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h200;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 5) mem_req = 1'b0;
      if (c == 9) if_req = 1'b0;
      @(negedge clk);
      n_checks += 3;
      if (ram_ce !== (c == 1 || c == 5)) begin n_fail++; $display("FAIL arb_ram_ce c%0d: got %b expected %b", c, ram_ce, c == 1 || c == 5); end
      if (mem_done !== (c == 4)) begin n_fail++; $display("FAIL arb_mem_done c%0d: got %b expected %b", c, mem_done, c == 4); end
      if (if_done !== (c == 8)) begin n_fail++; $display("FAIL arb_if_done c%0d: got %b expected %b", c, if_done, c == 8); end
      if (c == 1) begin
        n_checks += 3;
        if (ram_addr !== 32'h200) begin n_fail++; $display("FAIL arb_mem_addr: got %h expected 200", ram_addr); end
        if (state !== 2'd2) begin n_fail++; $display("FAIL arb_state: got %0d expected 2", state); end
        if (stallreq_if !== 1'b1) begin n_fail++; $display("FAIL arb_stall_if: got %b expected 1", stallreq_if); end
      end
      if (c == 4) begin
        n_checks++;
        if (mem_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL arb_mem_rdata: got %h expected cafef00d", mem_rdata); end
      end
      if (c == 5) begin
        n_checks++;
        if (ram_addr !== 32'h100) begin n_fail++; $display("FAIL arb_if_addr: got %h expected 100", ram_addr); end
      end
      if (c == 8) begin
        n_checks++;
        if (if_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL arb_if_rdata: got %h expected deadbeef", if_rdata); end
      end
    end
  endtask

  task automatic test_store();
    step();  // cycle 0
    mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011;
    mem_addr = 32'h40; mem_wdata = 32'h1234_ABCD;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 5) begin
        mem_req = 1'b0; mem_we = 1'b0;
        if_req = 1'b1; if_addr = 32'h40;  // read the stored word back
      end
      if (c == 10) if_req = 1'b0;
      @(negedge clk);
      n_checks += 3;
      if (ram_ce !== (c == 1 || c == 6)) begin n_fail++; $display("FAIL st_ram_ce c%0d: got %b expected %b", c, ram_ce, c == 1 || c == 6); end
      if (mem_done !== (c == 4)) begin n_fail++; $display("FAIL st_mem_done c%0d: got %b expected %b", c, mem_done, c == 4); end
      if (if_done !== (c == 9)) begin n_fail++; $display("FAIL st_if_done c%0d: got %b expected %b", c, if_done, c == 9); end
      if (c <= 3) begin
        n_checks += 4;
        if (ram_we !== 1'b1) begin n_fail++; $display("FAIL st_ram_we c%0d: got %b expected 1", c, ram_we); end
        if (ram_sel !== 4'b0011) begin n_fail++; $display("FAIL st_ram_sel c%0d: got %h expected 3", c, ram_sel); end
        if (ram_addr !== 32'h40) begin n_fail++; $display("FAIL st_ram_addr c%0d: got %h expected 40", c, ram_addr); end
        if (ram_wdata !== 32'h1234_ABCD) begin n_fail++; $display("FAIL st_ram_wdata c%0d: got %h expected 1234abcd", c, ram_wdata); end
      end
      if (c == 6) begin
        n_checks += 3;
        if (ram_we !== 1'b0) begin n_fail++; $display("FAIL st_rb_we: got %b expected 0", ram_we); end
        if (ram_sel !== 4'hF) begin n_fail++; $display("FAIL st_rb_sel: got %h expected f", ram_sel); end
        if (ram_wdata !== 32'd0) begin n_fail++; $display("FAIL st_rb_wdata: got %h expected 0", ram_wdata); end
      end
      if (c == 9) begin
        n_checks++;
        if (if_rdata !== 32'h0000_ABCD) begin n_fail++; $display("FAIL st_rb_rdata: got %h expected 0000abcd", if_rdata); end
      end
    end
  endtask

  task automatic test_flush();
    // Flush while BUSY_IF: access completes on the RAM but is not reported.
    step();  // cycle 0
    if_req = 1'b1; if_addr = 32'h200;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 2) if_flush = 1'b1;
      if (c == 3) begin if_flush = 1'b0; if_req = 1'b0; end
      @(negedge clk);
      n_checks += 2;
      if (ram_ce !== (c == 1)) begin n_fail++; $display("FAIL fl_ram_ce c%0d: got %b expected %b", c, ram_ce, c == 1); end
      if (if_done !== 1'b0) begin n_fail++; $display("FAIL fl_if_done c%0d: got %b expected 0", c, if_done); end
      if (c == 2) begin
        n_checks++;
        if (stallreq_if !== 1'b0) begin n_fail++; $display("FAIL fl_stall_if: got %b expected 0", stallreq_if); end
      end
    end
    n_checks++;
    if (if_rdata !== 32'h0000_ABCD) begin n_fail++; $display("FAIL fl_if_rdata_kept: got %h expected 0000abcd", if_rdata); end

    // Flush in IDLE blocks the grant; once it drops, the request proceeds.
    step();  // cycle 0
    if_req = 1'b1; if_flush = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    n_checks++;
    if (stallreq_if !== 1'b0) begin n_fail++; $display("FAIL fli_stall_if: got %b expected 0", stallreq_if); end
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) if_flush = 1'b0;
      if (c == 6) if_req = 1'b0;
      @(negedge clk);
      n_checks += 2;
      if (ram_ce !== (c == 2)) begin n_fail++; $display("FAIL fli_ram_ce c%0d: got %b expected %b", c, ram_ce, c == 2); end
      if (if_done !== (c == 5)) begin n_fail++; $display("FAIL fli_if_done c%0d: got %b expected %b", c, if_done, c == 5); end
      if (c == 5) begin
        n_checks++;
        if (if_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL fli_if_rdata: got %h expected deadbeef", if_rdata); end
      end
    end
  endtask

  task automatic test_mid_reset();
    step();  // cycle 0
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h200;
    step();  // cycle 1
    step();  // cycle 2
    rst = 1'b1;
    step();  // cycle 3: reset applied, mem_req still held
    rst = 1'b0;
    @(negedge clk);
    n_checks += 8;
    if (ram_ce !== 1'b0) begin n_fail++; $display("FAIL mr_ram_ce: got %b expected 0", ram_ce); end
    if (ram_addr !== 32'd0) begin n_fail++; $display("FAIL mr_ram_addr: got %h expected 0", ram_addr); end
    if (ram_sel !== 4'd0) begin n_fail++; $display("FAIL mr_ram_sel: got %h expected 0", ram_sel); end
    if (mem_rdata !== 32'd0) begin n_fail++; $display("FAIL mr_mem_rdata: got %h expected 0", mem_rdata); end
    if (if_rdata !== 32'd0) begin n_fail++; $display("FAIL mr_if_rdata: got %h expected 0", if_rdata); end
    if (mem_done !== 1'b0) begin n_fail++; $display("FAIL mr_mem_done: got %b expected 0", mem_done); end
    if (state !== 2'd0) begin n_fail++; $display("FAIL mr_state: got %0d expected 0", state); end
    if (stallreq_mem !== 1'b1) begin n_fail++; $display("FAIL mr_stall_mem: got %b expected 1", stallreq_mem); end
    for (int c = 4; c <= 8; c++) begin
      step();
      if (c == 8) mem_req = 1'b0;
      @(negedge clk);
      n_checks += 2;
      if (ram_ce !== (c == 4)) begin n_fail++; $display("FAIL mr_re_ram_ce c%0d: got %b expected %b", c, ram_ce, c == 4); end
      if (mem_done !== (c == 7)) begin n_fail++; $display("FAIL mr_re_mem_done c%0d: got %b expected %b", c, mem_done, c == 7); end
      if (c == 7) begin
        n_checks++;
        if (mem_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL mr_re_mem_rdata: got %h expected cafef00d", mem_rdata); end
      end
    end
  endtask

  task automatic test_back_to_back();
    step();  // cycle 0
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h200;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 5) mem_addr = 32'h100;  // second load presented right after done
      if (c == 10) mem_req = 1'b0;
      @(negedge clk);
      n_checks += 2;
      if (ram_ce !== (c == 1 || c == 6)) begin n_fail++; $display("FAIL b2b_ram_ce c%0d: got %b expected %b", c, ram_ce, c == 1 || c == 6); end
      if (mem_done !== (c == 4 || c == 9)) begin n_fail++; $display("FAIL b2b_mem_done c%0d: got %b expected %b", c, mem_done, c == 4 || c == 9); end
      if (c == 4) begin
        n_checks += 2;
        if (mem_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL b2b_rdata1: got %h expected cafef00d", mem_rdata); end
        if (stallreq_mem !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_done: got %b expected 0", stallreq_mem); end
      end
      if (c == 6) begin
        n_checks++;
        if (ram_addr !== 32'h100) begin n_fail++; $display("FAIL b2b_addr2: got %h expected 100", ram_addr); end
      end
      if (c == 9) begin
        n_checks++;
        if (mem_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL b2b_rdata2: got %h expected deadbeef", mem_rdata); end
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence + final report ----------------
  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_if_read();
    step();
    test_arbitration();
    step();
    test_store();
    step();
    test_flush();
    step();
    test_mid_reset();
    step();
    test_back_to_back();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
